alu_result_writeback: RTL and testbench

- Downstream of the ALU: accepts each completed ALU result pair (alu_out, alu_out2) with its opcode and destination register.
- Buffers results in a small FIFO and latches them into the Z register pair (zlow/zhigh).
- Sequences the writeback to the register file or the HI/LO registers through a request/grant bus handshake.
- Mul/div results take two bus writes; all other ops take one.

---
 rtl/alu_result_writeback_pkg.sv | 35 +++
 rtl/alu_result_writeback_fifo.sv | 53 +++++
 rtl/alu_result_writeback.sv | 134 +++++++++++++
 tb/tb_alu_result_writeback.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_writeback_pkg.sv
// Shared definitions for the ALU result writeback path: opcodes, bus select codes,
// FSM state encoding and opcode classification helpers.
package alu_result_writeback_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_LSR = 4'b0110;
  localparam logic [3:0] OP_ASR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_ROR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;

  localparam logic [1:0] WB_SEL_GPR = 2'b00;
  localparam logic [1:0] WB_SEL_LO  = 2'b01;
  localparam logic [1:0] WB_SEL_HI  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WB_PRI = 2'b01,
    WB_SEC = 2'b10
  } wb_state_t;

  function automatic logic is_two_write(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= OP_ROL;
  endfunction

endpackage

// File: rtl/alu_result_writeback_fifo.sv
// Parameterised synchronous FIFO buffering ALU results ahead of writeback.
// DEPTH must be a power of two (pointers wrap naturally).
module alu_wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_writeback.sv
// Buffers ALU results, latches them into zlow/zhigh and writes them back over a
// req/grant bus (two writes for mul/div). Optional NZ flags under ALU_WB_FLAGS_EN.
module alu_result_writeback
  import alu_result_writeback_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned RIDX_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [31:0]       in_lo,
  input  logic [31:0]       in_hi,
  input  logic [RIDX_W-1:0] in_rd,
  output logic              wb_req,
  input  logic              wb_grant,
  output logic [1:0]        wb_sel,
  output logic [RIDX_W-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic [31:0]       zlow,
  output logic [31:0]       zhigh,
  output logic              busy
`ifdef ALU_WB_FLAGS_EN
  ,
  output logic [1:0]        flags
`endif
);

  localparam int unsigned EW = 4 + 64 + RIDX_W;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_state_t         state, next_state;
  logic [EW-1:0]     f_wdata, f_rdata;
  logic              f_full, f_empty, f_pop;
  logic [CW-1:0]     f_count;
  logic [3:0]        h_op, op_q;
  logic [31:0]       h_lo, h_hi;
  logic [RIDX_W-1:0] h_rd, rd_q;
  logic              load_z;

  assign f_wdata = {in_op, in_hi, in_lo, in_rd};
  assign h_op    = f_rdata[EW-1 -: 4];
  assign h_hi    = f_rdata[RIDX_W+32 +: 32];
  assign h_lo    = f_rdata[RIDX_W +: 32];
  assign h_rd    = f_rdata[RIDX_W-1:0];

  alu_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (in_valid),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign in_ready = !f_full;
  assign busy     = (state != IDLE) || (f_count != '0);

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      zlow  <= '0;
      zhigh <= '0;
      op_q  <= '0;
      rd_q  <= '0;
    end else begin
      state <= next_state;
      if (load_z) begin
        zlow  <= h_lo;
        zhigh <= h_hi;
        op_q  <= h_op;
        rd_q  <= h_rd;
      end
    end
  end

`ifdef ALU_WB_FLAGS_EN
  always_ff @(posedge clock) begin
    if (clear)
      flags <= '0;
    else if (state == WB_PRI && wb_grant)
      flags <= {wb_data[31], (wb_data == '0)};
  end
`endif

  // Invalid opcodes are popped and dropped without touching Z or the bus.
  always_comb begin
    next_state = state;
    f_pop      = 1'b0;
    load_z     = 1'b0;
    wb_req     = 1'b0;
    wb_sel     = WB_SEL_GPR;
    wb_addr    = '0;
    wb_data    = '0;
    case (state)
      IDLE: begin
        if (!f_empty) begin
          f_pop = 1'b1;
          if (is_valid_op(h_op)) begin
            load_z     = 1'b1;
            next_state = WB_PRI;
          end
        end
      end
      WB_PRI: begin
        wb_req = 1'b1;
        if (is_two_write(op_q)) begin
          wb_sel  = WB_SEL_LO;
          wb_data = (op_q == OP_DIV) ? zhigh : zlow;
        end else begin
          wb_addr = rd_q;
          wb_data = zlow;
        end
        if (wb_grant) next_state = is_two_write(op_q) ? WB_SEC : IDLE;
      end
      WB_SEC: begin
        wb_req  = 1'b1;
        wb_sel  = WB_SEL_HI;
        wb_data = (op_q == OP_DIV) ? zlow : zhigh;
        if (wb_grant) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Scoreboard bench for alu_result_writeback: expected bus writes are queued at
// stimulus time and checked by a monitor on every granted request.
module tb_alu_result_writeback;

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_lo = '0;
  logic [31:0] in_hi = '0;
  logic [3:0]  in_rd = '0;
  logic        wb_req;
  logic        wb_grant = 1'b0;
  logic [1:0]  wb_sel;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] zlow;
  logic [31:0] zhigh;
  logic        busy;
`ifdef ALU_WB_FLAGS_EN
  logic [1:0]  flags;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t e;

  alu_result_writeback #(
    .DEPTH  (2),
    .RIDX_W (4)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_lo    (in_lo),
    .in_hi    (in_hi),
    .in_rd    (in_rd),
    .wb_req   (wb_req),
    .wb_grant (wb_grant),
    .wb_sel   (wb_sel),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .zlow     (zlow),
    .zhigh    (zhigh),
    .busy     (busy)
`ifdef ALU_WB_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  always #5 clock = ~clock;

  // Monitor: every granted request must match the head of the scoreboard.
  always @(negedge clock) begin
    if (wb_req === 1'b1 && wb_grant === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got sel=%b addr=%h data=%h, expected no write",
                 wb_sel, wb_addr, wb_data);
      end else begin
        e = q.pop_front();
        if ({wb_sel, wb_addr, wb_data} !== e) begin
          fails++;
          $display("FAIL bus_write: got sel=%b addr=%h data=%h, expected sel=%b addr=%h data=%h",
                   wb_sel, wb_addr, wb_data, e.sel, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] lo, input logic [31:0] hi,
                      input logic [3:0] rd);
    int w;
    in_op = op; in_lo = lo; in_hi = hi; in_rd = rd;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL push_wait: got in_ready=0 after %0d cycles, expected 1", w);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      tick();
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    check("rst_wb_req",   32'(wb_req),   32'd0);
    check("rst_wb_sel",   32'(wb_sel),   32'd0);
    check("rst_wb_addr",  32'(wb_addr),  32'd0);
    check("rst_wb_data",  wb_data,       32'd0);
    check("rst_zlow",     zlow,          32'd0);
    check("rst_zhigh",    zhigh,         32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_WB_FLAGS_EN
    check("rst_flags",    32'(flags),    32'd0);
`endif

    // Single add, grant tied high
    wb_grant = 1'b1;
    q.push_back('{2'b00, 4'd3, 32'h0000_0015});
    push(4'b0000, 32'h0000_0015, 32'h0, 4'd3);
    tick();
    check("add_zlow",   zlow,          32'h15);
    check("add_req",    32'(wb_req),   32'd1);
    tick();
    check("add_busy",   32'(busy),     32'd0);

    // Mul: LO then HI
    q.push_back('{2'b01, 4'd0, 32'hFFFF_FFF0});
    q.push_back('{2'b10, 4'd0, 32'hFFFF_FFFF});
    push(4'b0011, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 4'd0);
    wait_idle("mul_idle");
    check("mul_zhigh", zhigh, 32'hFFFF_FFFF);

    // Div: quotient to LO, remainder to HI
    q.push_back('{2'b01, 4'd0, 32'h7});
    q.push_back('{2'b10, 4'd0, 32'h2});
    push(4'b0010, 32'h2, 32'h7, 4'd0);
    wait_idle("div_idle");

    // Backpressure
    wb_grant = 1'b0;
    q.push_back('{2'b00, 4'd1, 32'h111});
    q.push_back('{2'b01, 4'd0, 32'hA});
    q.push_back('{2'b10, 4'd0, 32'hB});
    q.push_back('{2'b00, 4'd2, 32'h222});
    push(4'b0000, 32'h111, 32'h0, 4'd1);
    push(4'b0011, 32'hA,   32'hB, 4'd0);
    push(4'b0001, 32'h222, 32'h0, 4'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("bp_req",  32'(wb_req),  32'd1);
      check("bp_sel",  32'(wb_sel),  32'd0);
      check("bp_addr", 32'(wb_addr), 32'd1);
      check("bp_data", wb_data,      32'h111);
      tick();
    end
    wb_grant = 1'b1;
    wait_idle("bp_idle");

    // Invalid opcode between two adds
    q.push_back('{2'b00, 4'd4, 32'h44});
    push(4'b0000, 32'h44, 32'h0, 4'd4);
    wait_idle("inv_idle1");
    push(4'b1100, 32'hDEAD, 32'hBEEF, 4'd9);
    wait_idle("inv_idle2");
    check("inv_zlow",  zlow,  32'h44);
    check("inv_zhigh", zhigh, 32'h0);
    q.push_back('{2'b00, 4'd5, 32'h55});
    push(4'b0000, 32'h55, 32'h0, 4'd5);
    wait_idle("inv_idle3");
    check("inv_zlow2", zlow, 32'h55);

    // Clear during WB_SEC of a mul
    wb_grant = 1'b0;
    q.push_back('{2'b01, 4'd0, 32'h8000_1234});
    push(4'b0011, 32'h8000_1234, 32'h5678, 4'd0);
    tick();
    check("rmid_req_pri", 32'(wb_req), 32'd1);
    wb_grant = 1'b1;
    tick();
    wb_grant = 1'b0;
    check("rmid_sec_req",  32'(wb_req), 32'd1);
    check("rmid_sec_sel",  32'(wb_sel), 32'd2);
    check("rmid_sec_data", wb_data,     32'h5678);
`ifdef ALU_WB_FLAGS_EN
    check("rmid_flags_n", 32'(flags), 32'd2);
`endif
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("rmid_req",      32'(wb_req),   32'd0);
    check("rmid_zlow",     zlow,          32'd0);
    check("rmid_zhigh",    zhigh,         32'd0);
    check("rmid_in_ready", 32'(in_ready), 32'd1);
    check("rmid_busy",     32'(busy),     32'd0);
`ifdef ALU_WB_FLAGS_EN
    check("rmid_flags",    32'(flags),    32'd0);
`endif
    wb_grant = 1'b1;
    repeat (5) tick();

    q.push_back('{2'b00, 4'd7, 32'h0});
    push(4'b0000, 32'h0, 32'h0, 4'd7);
    wait_idle("zero_idle");
`ifdef ALU_WB_FLAGS_EN
    check("zero_flags", 32'(flags), 32'd1);
`endif

    tick();
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
